// File: rtl/spi_regmap_pkg.sv
// Shared constants and FSM state type for the SPI register-map front end.
package spi_regmap_pkg;

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned RW_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a history flop; flags rising/falling edges of an async pin.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Reset to 0 so a chip select already low at reset release never looks like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_regmap_burst.sv
// SPI mode-0 slave register map: command byte, then burst of DATA_W-bit words with address auto-increment.
module spi_regmap_burst
  import spi_regmap_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_REGS = 16,
  parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sclk,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_stb_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic                         rd_stb_o,
  output logic                         addr_err_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic mosi_s1, mosi_s;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CMD_W-2:0]    cmd_sh;
  logic [ADDR_W-1:0]   addr;
  logic                is_write;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [ADDR_W-1:0]   load_addr;
  logic                load_ok;
  logic [DATA_W-1:0]   load_word;

  spi_sync_edge u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_sclk),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_s1 <= 1'b0;
      mosi_s  <= 1'b0;
    end else begin
      mosi_s1 <= spi_mosi;
      mosi_s  <= mosi_s1;
    end
  end

  // During the last command bit the address is not yet in cmd_sh; splice in the live MOSI bit.
  always_comb begin
    load_addr = (state == ST_CMD) ? {cmd_sh[ADDR_W-2:0], mosi_s} : addr;
    load_ok   = ({1'b0, load_addr} < (ADDR_W + 1)'(NUM_REGS));
    load_word = load_ok ? regs[load_addr[IDX_W-1:0]] : '0;
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++) begin
      regs_o[n*DATA_W +: DATA_W] = regs[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      addr        <= '0;
      is_write    <= 1'b0;
      shreg       <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_stb_o    <= 1'b0;
      wr_addr_o   <= '0;
      rd_stb_o    <= 1'b0;
      addr_err_o  <= 1'b0;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
        regs[n] <= RST_VAL;
      end
    end else begin
      wr_stb_o   <= 1'b0;
      rd_stb_o   <= 1'b0;
      addr_err_o <= 1'b0;
      if (cs_rise) begin
        state       <= ST_IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              cmd_sh  <= {cmd_sh[CMD_W-3:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_CMD) begin
                state    <= ST_DATA;
                bit_cnt  <= '0;
                is_write <= cmd_sh[RW_BIT-1];
                if (cmd_sh[RW_BIT-1]) begin
                  addr <= load_addr;
                end else begin
                  shreg       <= load_word;
                  rd_stb_o    <= 1'b1;
                  addr_err_o  <= ~load_ok;
                  addr        <= load_addr + 1'b1;
                  spi_miso_oe <= 1'b1;
                end
              end
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
              if (is_write) begin
                shreg <= {shreg[DATA_W-2:0], mosi_s};
              end
              if (bit_cnt == LAST_DATA) begin
                addr <= addr + 1'b1;
                if (is_write) begin
                  if (load_ok) begin
                    regs[load_addr[IDX_W-1:0]] <= {shreg[DATA_W-2:0], mosi_s};
                    wr_stb_o  <= 1'b1;
                    wr_addr_o <= addr;
                  end else begin
                    addr_err_o <= 1'b1;
                  end
                end else begin
                  shreg      <= load_word;
                  rd_stb_o   <= 1'b1;
                  addr_err_o <= ~load_ok;
                end
              end
            end else if (sck_fall && !is_write) begin
              spi_miso <= shreg[DATA_W-1];
              shreg    <= {shreg[DATA_W-2:0], 1'b0};
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_regmap_burst.sv
// Directed bench for spi_regmap_burst: 32-bit and 16-bit instances sharing SCLK/MOSI, separate chip selects.
module tb_spi_regmap_burst;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst32, rst16, sclk, cs32, cs16, mosi;

  logic          miso32, oe32, wr_stb32, rd_stb32, err32;
  logic [6:0]    wr_addr32;
  logic [511:0]  regs32;
  logic          miso16, oe16, wr_stb16, rd_stb16, err16;
  logic [6:0]    wr_addr16;
  logic [255:0]  regs16;

  int total = 0;
  int bad   = 0;

  int wr32_n = 0, rd32_n = 0, err32_n = 0, wr16_n = 0;
  logic [6:0] wa32_q [$];

  logic [31:0] tx_words [4];
  logic [31:0] rx_words [4];

  always #5 clk = ~clk;

  spi_regmap_burst #(.DATA_W(32), .NUM_REGS(16), .RST_VAL(32'h0)) dut32 (
    .clk(clk), .rst(rst32), .spi_sclk(sclk), .spi_cs_n(cs32), .spi_mosi(mosi),
    .spi_miso(miso32), .spi_miso_oe(oe32), .regs_o(regs32), .wr_stb_o(wr_stb32),
    .wr_addr_o(wr_addr32), .rd_stb_o(rd_stb32), .addr_err_o(err32)
  );

  spi_regmap_burst #(.DATA_W(16), .NUM_REGS(16), .RST_VAL(16'h5a5a)) dut16 (
    .clk(clk), .rst(rst16), .spi_sclk(sclk), .spi_cs_n(cs16), .spi_mosi(mosi),
    .spi_miso(miso16), .spi_miso_oe(oe16), .regs_o(regs16), .wr_stb_o(wr_stb16),
    .wr_addr_o(wr_addr16), .rd_stb_o(rd_stb16), .addr_err_o(err16)
  );

  always @(negedge clk) begin
    if (wr_stb32) begin
      wr32_n++;
      wa32_q.push_back(wr_addr32);
    end
    if (rd_stb32) rd32_n++;
    if (err32)    err32_n++;
    if (wr_stb16) wr16_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input int sel, input logic b, output logic m, output logic oe);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m  = (sel == 1) ? miso16 : miso32;
    oe = (sel == 1) ? oe16 : oe32;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic cs_set(input int sel, input logic v);
    if (sel == 1) cs16 = v;
    else          cs32 = v;
  endtask

  // Sends cmd then nbits data bits taken MSB-first from tx_words; collects MISO words.
  task automatic xfer(input int sel, input logic [7:0] cmd, input int wbits,
                      input int nbits, output int oe_bad);
    logic m, oe;
    logic [31:0] w, r;
    int k, i;
    oe_bad = 0;
    cs_set(sel, 1'b0);
    repeat (4) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      spi_bit(sel, cmd[7-b], m, oe);
      if (oe !== 1'b0) oe_bad++;
    end
    r = '0;
    for (int n = 0; n < nbits; n++) begin
      k = n / wbits;
      i = n % wbits;
      w = tx_words[k];
      spi_bit(sel, w[wbits-1-i], m, oe);
      r = {r[30:0], m};
      if (oe !== ~cmd[7]) oe_bad++;
      if (i == wbits - 1) begin
        rx_words[k] = r;
        r = '0;
      end
    end
    repeat (HALF) @(negedge clk);
    cs_set(sel, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic [31:0] exp_miso;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int w0, r0, e0, q0, ob;
    logic m, oe;

    vecs[0] = '{8'h85, 32'h17f3ad08, 32'h0,        1, 0, 0};
    vecs[1] = '{8'h05, 32'h0,        32'h17f3ad08, 0, 2, 0};
    vecs[2] = '{8'hFF, 32'hdeadbeef, 32'h0,        0, 0, 1};
    vecs[3] = '{8'h7F, 32'h0,        32'h0,        0, 2, 1};
    vecs[4] = '{8'h8F, 32'hcafef00d, 32'h0,        1, 0, 0};
    vecs[5] = '{8'h0F, 32'h0,        32'hcafef00d, 0, 2, 1};
    vecs[6] = '{8'h90, 32'h12345678, 32'h0,        0, 0, 1};
    vecs[7] = '{8'h80, 32'ha5a5c3c3, 32'h0,        1, 0, 0};
    vecs[8] = '{8'h00, 32'h0,        32'ha5a5c3c3, 0, 2, 0};

    rst32 = 1'b1; rst16 = 1'b1;
    sclk = 1'b0; cs32 = 1'b1; cs16 = 1'b1; mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst32 = 1'b0; rst16 = 1'b0;
    repeat (6) @(negedge clk);

    check("rst_miso32", {31'b0, miso32}, 32'h0);
    check("rst_oe32", {31'b0, oe32}, 32'h0);
    check("rst_wr_addr32", {25'b0, wr_addr32}, 32'h0);
    check("rst_strobes32", {29'b0, wr_stb32, rd_stb32, err32}, 32'h0);
    for (int n = 0; n < 16; n++) begin
      check($sformatf("rst_reg32_%0d", n), regs32[n*32 +: 32], 32'h0);
      check($sformatf("rst_reg16_%0d", n), {16'h0, regs16[n*16 +: 16]}, 32'h5a5a);
    end

    for (int v = 0; v < 9; v++) begin
      w0 = wr32_n; r0 = rd32_n; e0 = err32_n;
      tx_words[0] = vecs[v].wdata;
      rx_words[0] = '0;
      xfer(0, vecs[v].cmd, 32, 32, ob);
      if (!vecs[v].cmd[7]) check($sformatf("v%0d_miso_word", v), rx_words[0], vecs[v].exp_miso);
      check($sformatf("v%0d_wr_cnt", v), wr32_n - w0, vecs[v].exp_wr);
      check($sformatf("v%0d_rd_cnt", v), rd32_n - r0, vecs[v].exp_rd);
      check($sformatf("v%0d_err_cnt", v), err32_n - e0, vecs[v].exp_err);
      check($sformatf("v%0d_oe_window", v), ob, 0);
      check($sformatf("v%0d_idle_pins", v), {30'b0, oe32, miso32}, 32'h0);
      if (vecs[v].exp_wr == 1) begin
        check($sformatf("v%0d_reg", v), regs32[vecs[v].cmd[3:0]*32 +: 32], vecs[v].wdata);
        check($sformatf("v%0d_wr_addr", v), {25'b0, wr_addr32}, {25'b0, vecs[v].cmd[6:0]});
      end
    end
    check("no_reg_at_err", regs32[15*32 +: 32], 32'hcafef00d);

    // Burst write of three words
    w0 = wr32_n; q0 = wa32_q.size();
    tx_words[0] = 32'h11111111; tx_words[1] = 32'h22222222; tx_words[2] = 32'h33333333;
    xfer(0, 8'h82, 32, 96, ob);
    check("burst_wr_cnt", wr32_n - w0, 3);
    check("burst_reg2", regs32[2*32 +: 32], 32'h11111111);
    check("burst_reg3", regs32[3*32 +: 32], 32'h22222222);
    check("burst_reg4", regs32[4*32 +: 32], 32'h33333333);
    check("burst_reg5_kept", regs32[5*32 +: 32], 32'h17f3ad08);
    check("burst_addr_cnt", wa32_q.size() - q0, 3);
    for (int n = 0; n < 3; n++) begin
      if (q0 + n < wa32_q.size())
        check($sformatf("burst_wr_addr%0d", n), {25'b0, wa32_q[q0+n]}, 32'(2 + n));
    end

    // Burst read back
    r0 = rd32_n;
    xfer(0, 8'h02, 32, 64, ob);
    check("bread_w0", rx_words[0], 32'h11111111);
    check("bread_w1", rx_words[1], 32'h22222222);
    check("bread_rd_cnt", rd32_n - r0, 3);
    check("bread_oe", ob, 0);

    // Partial word aborted by chip-select release
    w0 = wr32_n;
    tx_words[0] = 32'hffffffff;
    xfer(0, 8'h84, 32, 20, ob);
    check("partial_reg4", regs32[4*32 +: 32], 32'h33333333);
    check("partial_wr_cnt", wr32_n - w0, 0);
    tx_words[0] = 32'h0badf00d;
    xfer(0, 8'h84, 32, 32, ob);
    check("after_partial_reg4", regs32[4*32 +: 32], 32'h0badf00d);
    check("after_partial_wr_cnt", wr32_n - w0, 1);

    // 16-bit instance: write, then reset mid-word
    w0 = wr16_n;
    tx_words[0] = 32'h0000dead;
    xfer(1, 8'h8A, 16, 16, ob);
    check("w16_reg10", {16'h0, regs16[10*16 +: 16]}, 32'hdead);
    check("w16_wr_addr", {25'b0, wr_addr16}, 32'd10);
    check("w16_wr_cnt", wr16_n - w0, 1);

    w0 = wr16_n;
    cs16 = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < 8; b++) spi_bit(1, 1'(8'h8B >> (7 - b)), m, oe);
    for (int b = 0; b < 8; b++) spi_bit(1, 1'(16'hbeef >> (15 - b)), m, oe);
    rst16 = 1'b1;
    repeat (3) @(negedge clk);
    rst16 = 1'b0;
    for (int b = 8; b < 16; b++) spi_bit(1, 1'(16'hbeef >> (15 - b)), m, oe);
    repeat (HALF) @(negedge clk);
    cs16 = 1'b1;
    repeat (6) @(negedge clk);
    check("rst16_wr_cnt", wr16_n - w0, 0);
    for (int n = 0; n < 16; n++)
      check($sformatf("rst16_reg%0d", n), {16'h0, regs16[n*16 +: 16]}, 32'h5a5a);

    tx_words[0] = 32'h0000beef;
    xfer(1, 8'h8B, 16, 16, ob);
    check("w16_reg11", {16'h0, regs16[11*16 +: 16]}, 32'hbeef);
    xfer(1, 8'h0B, 16, 16, ob);
    check("r16_miso_word", rx_words[0], 32'h0000beef);
    check("r16_oe", ob, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_regmap_burst.md
# spi_regmap_burst

Parametrised SPI-slave register map with burst auto-increment and read-back, replacing the fixed 32-bit single-access regmap front end. It oversamples an SPI mode-0 bus on the system clock and decodes a command byte followed by one or more DATA_W-bit words. It writes or reads a bank of NUM_REGS registers whose contents are exported flat to the datapath. It sits between the chip-level SPI pads and the crypto accelerator's configuration registers.

## Interface
- DATA_W, 32: word width in bits; legal values 8, 16, 32.
- NUM_REGS, 16: implemented registers, 1..128; address width is fixed at 7.
- RST_VAL, 0: reset value of every register, DATA_W bits.
- clk  in  1  system clock; must be ≥ 4× SCLK frequency.
- rst  in  1  reset, asynchronous and active-high.
- spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out; 0 when not driving.
- spi_miso_oe  out  1  pad output enable.
- regs_o  out  NUM_REGS*DATA_W  register contents; reg n is at bits [n*DATA_W +: DATA_W].
- wr_stb_o  out  1  one-clk pulse per committed write.
- wr_addr_o  out  7  address of the last write; held between pulses.
- rd_stb_o  out  1  one-clk pulse per word loaded for read.
- addr_err_o  out  1  one-clk pulse on any access with address ≥ NUM_REGS.

## Operation
- spi_sclk, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser, then a third flop for edge detection: sck_rise, sck_fall, cs_fall, cs_rise.
- FSM states:
  - IDLE → CMD on cs_fall.
  - CMD: shift 8 bits on sck_rise. Bit7 = 1 write, 0 read; bits6:0 = start address. After the 8th bit, go to DATA with addr = cmd[6:0] and bit count = 0.
  - DATA: a write shifts DATA_W bits from MOSI. On the last bit, commit to regs[addr] when addr < NUM_REGS, else pulse addr_err_o. Then addr ← addr+1, wrapping 127 → 0.
- Read: on the 8th command bit, and on the last bit of every data word, load shreg ← regs[addr]. Load 0 when addr ≥ NUM_REGS and pulse addr_err_o. Pulse rd_stb_o and post-increment addr. Each sck_fall in DATA drives spi_miso ← shreg MSB, then shifts left.
- Burst: words continue until cs_rise; no length field.
- cs_rise in any state → IDLE. A partial word is discarded with no write and no strobe. spi_miso and spi_miso_oe go to 0.
- spi_miso_oe = 1 only in DATA of a read transaction.

## Timing
- Reset values: all regs = RST_VAL; spi_miso, spi_miso_oe, wr_stb_o, rd_stb_o and addr_err_o = 0; wr_addr_o = 0; FSM in IDLE.
- Synchroniser latency is 3 clk from a pin edge to its detect pulse.
- Write: regs_o, wr_stb_o and wr_addr_o all update in the clk edge after the last bit's sck_rise. The new value is visible 1 clk after that detect.
- Read: the first MISO bit is valid 1 clk after the sck_fall that follows the 8th command rising edge, i.e. half an SCLK period before the master samples it.
- If a write commit and a read load hit the same register in the same clk, the read returns the pre-write value. This cannot occur within one transaction and is listed only for completeness.
- Reset asserted mid-transaction aborts it. The FSM stays in IDLE until a fresh cs_fall, so a transfer still in progress when reset releases is ignored.

## Structure
- The shared package spi_regmap_pkg holds CMD_W = 8, ADDR_W = 7, the FSM state enum, and the RW bit index.
- One sub-module, spi_sync_edge: a 3-flop synchroniser with rise/fall outputs, instantiated for spi_sclk and spi_cs_n. spi_mosi uses only the 2-flop sync.

## Test plan
- DATA_W=32, write cmd 0x85, data 0x17f3ad08 → regs[5] = 0x17f3ad08; one wr_stb_o with wr_addr_o = 5.
- Burst write cmd 0x82 with 0x11111111, 0x22222222, 0x33333333 → regs[2..4] updated in order; three strobes with wr_addr_o = 2, 3, 4.
- Read cmd 0x05 after the first test → MISO returns 0x17f3ad08 MSB-first; spi_miso_oe is high only during the data word.
- Write cmd 0xFF with data 0xdeadbeef, NUM_REGS=16 → no register changes; one addr_err_o pulse. Read 0x7F then returns 0.
- cs_n deasserted after 20 data bits of a write to reg 4 → regs[4] unchanged, no wr_stb_o; the next full transaction succeeds.
- DATA_W=16, write cmd 0x8A with 0xdead → regs[10] = 0xdead. Pulse rst mid-word → all regs = RST_VAL, and the aborted word is never committed.
